// File: rtl/converge_seq_pkg.sv
// Shared definitions for the converge_seq off-diagonal energy sequencer:
// FSM state encoding, derived-width helpers and the threshold width.
package converge_seq_pkg;

  localparam int THR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Wide enough to sum N*N full-scale squares without overflow.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n * n);
  endfunction

  function automatic int cnt_width(input int max_sweeps);
    return $clog2(max_sweeps + 1);
  endfunction

endpackage

// File: rtl/converge_seq_sq_acc.sv
// Registered squarer followed by a saturating accumulator; one element per
// enabled cycle, zero_in forces that element's contribution to zero.
module sq_acc #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 36
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    clr_in,
  input  logic                    en_in,
  input  logic                    zero_in,
  input  logic signed [WIDTH-1:0] data_in,
  output logic [ACC_W-1:0]        acc_out
);

  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0]        sq_q;
  logic                      sq_vld_q;
  logic [ACC_W-1:0]          acc_q;
  logic [ACC_W:0]            sum_wide;

  assign prod     = (2*WIDTH)'(data_in) * (2*WIDTH)'(data_in);
  assign sum_wide = {1'b0, acc_q} + (ACC_W+1)'(sq_q);
  assign acc_out  = acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sq_q     <= '0;
      sq_vld_q <= 1'b0;
      acc_q    <= '0;
    end else if (clr_in) begin
      sq_q     <= '0;
      sq_vld_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      sq_vld_q <= en_in;
      if (en_in) sq_q <= zero_in ? '0 : $unsigned(prod);
      // Carry out of the top bit pins the sum at all-ones instead of wrapping.
      if (sq_vld_q) acc_q <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/converge_seq.sv
// Sweeps an N x N matrix stream, accumulates the off-diagonal energy and
// decides convergence, divergence or timeout after every sweep.
module converge_seq
  import converge_seq_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int FRACT      = 8,
  parameter  int N_STOCKS   = 4,
  parameter  int MAX_SWEEPS = 16,
  localparam int ACC_W      = acc_width(WIDTH, N_STOCKS),
  localparam int CNT_W      = cnt_width(MAX_SWEEPS)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic                    abort_in,
  input  logic [THR_W-1:0]        thr_in,
  input  logic signed [WIDTH-1:0] elem_in,
  input  logic                    elem_valid_in,
  output logic                    elem_ready_out,
  output logic                    result_valid_out,
  output logic                    conv_out,
  output logic                    diverge_out,
  output logic                    timeout_out,
  output logic                    busy_out,
  output logic [ACC_W-1:0]        sum_out,
  output logic [CNT_W-1:0]        sweep_cnt_out
);

  localparam int                    IDX_W    = $clog2(N_STOCKS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_STOCKS - 1);
  localparam logic [CNT_W-1:0]      MAX_CNT  = CNT_W'(MAX_SWEEPS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]   sweep_q, sweep_d, sweep_inc;
  logic [ACC_W-1:0]   prev_q, prev_d, sum_q, sum_d;
  logic [THR_W-1:0]   thr_q, thr_d;
  logic               conv_q, conv_d, div_q, div_d, tmo_q, tmo_d, rv_q, rv_d;
  logic               acc_clr, acc_en, accept, last_elem, conv_now;
  logic [ACC_W-1:0]   acc;

  sq_acc #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_sq_acc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr_in   (acc_clr),
    .en_in    (acc_en),
    .zero_in  (row_q == col_q),
    .data_in  (elem_in),
    .acc_out  (acc)
  );

  assign accept    = (state_q == ST_ACCUM) && elem_valid_in;
  assign last_elem = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign sweep_inc = sweep_q + CNT_W'(1);
  assign conv_now  = 64'(acc >> FRACT) < (64'd1 << thr_q);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    sweep_d = sweep_q;
    prev_d  = prev_q;
    sum_d   = sum_q;
    thr_d   = thr_q;
    conv_d  = conv_q;
    div_d   = div_q;
    tmo_d   = tmo_q;
    rv_d    = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;

    if (abort_in) begin
      state_d = ST_IDLE;
      conv_d  = 1'b0;
      div_d   = 1'b0;
      tmo_d   = 1'b0;
      acc_clr = 1'b1;
    end else if (start_in) begin
      // Restart from any state; an element presented this cycle is dropped.
      state_d = ST_ACCUM;
      row_d   = '0;
      col_d   = '0;
      sweep_d = '0;
      prev_d  = '0;
      thr_d   = thr_in;
      conv_d  = 1'b0;
      div_d   = 1'b0;
      tmo_d   = 1'b0;
      acc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            acc_en = 1'b1;
            if (col_q == LAST_IDX) begin
              col_d = '0;
              row_d = row_q + IDX_W'(1);
            end else begin
              col_d = col_q + IDX_W'(1);
            end
            if (last_elem) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: state_d = ST_EVAL;
        ST_EVAL: begin
          sum_d   = acc;
          conv_d  = conv_now;
          div_d   = (sweep_q != '0) && (acc > prev_q);
          sweep_d = sweep_inc;
          prev_d  = acc;
          rv_d    = 1'b1;
          if (conv_now) begin
            state_d = ST_DONE;
          end else if (sweep_inc == MAX_CNT) begin
            tmo_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
            row_d   = '0;
            col_d   = '0;
            acc_clr = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      sweep_q <= '0;
      prev_q  <= '0;
      sum_q   <= '0;
      thr_q   <= '0;
      conv_q  <= 1'b0;
      div_q   <= 1'b0;
      tmo_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sweep_q <= sweep_d;
      prev_q  <= prev_d;
      sum_q   <= sum_d;
      thr_q   <= thr_d;
      conv_q  <= conv_d;
      div_q   <= div_d;
      tmo_q   <= tmo_d;
      rv_q    <= rv_d;
    end
  end

  assign elem_ready_out   = (state_q == ST_ACCUM);
  assign busy_out         = (state_q == ST_ACCUM) || (state_q == ST_DRAIN) ||
                            (state_q == ST_EVAL);
  assign result_valid_out = rv_q;
  assign conv_out         = conv_q;
  assign diverge_out      = div_q;
  assign timeout_out      = tmo_q;
  assign sum_out          = sum_q;
  assign sweep_cnt_out    = sweep_q;

endmodule
